// File: rtl/bmem_arbiter_pkg.sv
// Shared types and sizing for the icache/dcache burst-memory arbiter.
// The line is BMEM_BEATS beats of BEAT_WIDTH bits each, and line addresses are aligned to LINE_OFFSET_BITS.
package bmem_arbiter_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int BEAT_WIDTH       = 64;
    localparam int BMEM_BEATS       = 4;
    localparam int LINE_WIDTH       = BEAT_WIDTH * BMEM_BEATS;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int BEAT_CNT_W       = $clog2(BMEM_BEATS);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_RD_ISSUE,
        ARB_RD_WAIT,
        ARB_WR_BURST,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {ARB_I, ARB_D} arb_owner_t;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/bmem_arbiter_if.sv
// Bundle of both cache line ports and the burst memory port.
// The master modport is the arbiter side; the slave modport is the caches plus memory.
interface bmem_arbiter_if;
    import bmem_arbiter_pkg::*;

    logic [ADDR_WIDTH-1:0] i_dfp_addr;
    logic                  i_dfp_read;
    logic                  i_dfp_write;
    logic [LINE_WIDTH-1:0] i_dfp_wdata;
    logic [LINE_WIDTH-1:0] i_dfp_rdata;
    logic                  i_dfp_resp;

    logic [ADDR_WIDTH-1:0] d_dfp_addr;
    logic                  d_dfp_read;
    logic                  d_dfp_write;
    logic [LINE_WIDTH-1:0] d_dfp_wdata;
    logic [LINE_WIDTH-1:0] d_dfp_rdata;
    logic                  d_dfp_resp;

    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [ADDR_WIDTH-1:0] bmem_raddr;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_rvalid;

    modport master (
        input  i_dfp_addr, i_dfp_read, i_dfp_write, i_dfp_wdata,
        output i_dfp_rdata, i_dfp_resp,
        input  d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        output d_dfp_rdata, d_dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        output i_dfp_addr, i_dfp_read, i_dfp_write, i_dfp_wdata,
        input  i_dfp_rdata, i_dfp_resp,
        output d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        input  d_dfp_rdata, d_dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

endinterface

// File: rtl/bmem_arbiter_line_beat_buffer.sv
// Cacheline register plus beat counter.
// Read beats are written into the slot selected by the counter; write beats are read out of that same slot.
module line_beat_buffer
    import bmem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [LINE_WIDTH-1:0] i_load_line,
    input  logic                  i_shift_in,
    input  logic [BEAT_WIDTH-1:0] i_beat,
    input  logic                  i_advance,
    output logic [LINE_WIDTH-1:0] o_line,
    output logic [BEAT_WIDTH-1:0] o_beat,
    output logic [BEAT_CNT_W-1:0] o_beat_cnt,
    output logic                  o_last
);

    logic [LINE_WIDTH-1:0] r_line;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;

    // The counter wraps naturally back to 0 after the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line     <= '0;
            r_beat_cnt <= '0;
        end else if (i_load) begin
            r_line     <= i_load_line;
            r_beat_cnt <= '0;
        end else if (i_shift_in) begin
            r_line[BEAT_WIDTH*r_beat_cnt +: BEAT_WIDTH] <= i_beat;
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
        end else if (i_advance) begin
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
        end
    end

    assign o_line     = r_line;
    assign o_beat     = r_line[BEAT_WIDTH*r_beat_cnt +: BEAT_WIDTH];
    assign o_beat_cnt = r_beat_cnt;
    assign o_last     = (r_beat_cnt == BEAT_CNT_W'(BMEM_BEATS-1));

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter that shares the burst memory port between icache and dcache.
// It handles one line transaction at a time and splits or assembles lines as 64-bit beats.
module bmem_arbiter
    import bmem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    bmem_arbiter_if.master        bus,
    output arb_state_t            o_state,
    output logic [BEAT_CNT_W-1:0] o_beat_cnt
);

    arb_state_t            r_state, w_state_nxt;
    arb_owner_t            r_owner, r_last_grant, w_grant;
    logic                  r_op_write, r_cool_i, r_cool_d;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_elig_i, w_elig_d, w_grant_en, w_grant_write;
    logic [ADDR_WIDTH-1:0] w_grant_addr;
    logic [LINE_WIDTH-1:0] w_grant_wdata, w_line;
    logic [BEAT_WIDTH-1:0] w_beat;
    logic [BEAT_CNT_W-1:0] w_beat_cnt;
    logic                  w_last_beat, w_load, w_shift_in, w_advance;
    logic                  w_bmem_read, w_bmem_write, w_resp_i, w_resp_d;

    // A cache that has just been answered sits out one IDLE cycle, so a request it still holds is not served twice.
    assign w_elig_i = (bus.i_dfp_read | bus.i_dfp_write) & ~r_cool_i;
    assign w_elig_d = (bus.d_dfp_read | bus.d_dfp_write) & ~r_cool_d;

    always_comb begin
        w_grant_en = 1'b0;
        w_grant    = ARB_I;
        if (w_elig_i && w_elig_d) begin
            w_grant_en = 1'b1;
            w_grant    = (r_last_grant == ARB_I) ? ARB_D : ARB_I;
        end else if (w_elig_i) begin
            w_grant_en = 1'b1;
            w_grant    = ARB_I;
        end else if (w_elig_d) begin
            w_grant_en = 1'b1;
            w_grant    = ARB_D;
        end
    end

    assign w_grant_write = (w_grant == ARB_I) ? bus.i_dfp_write : bus.d_dfp_write;
    assign w_grant_addr  = (w_grant == ARB_I) ? bus.i_dfp_addr  : bus.d_dfp_addr;
    assign w_grant_wdata = (w_grant == ARB_I) ? bus.i_dfp_wdata : bus.d_dfp_wdata;

    line_beat_buffer u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_line (w_grant_wdata),
        .i_shift_in  (w_shift_in),
        .i_beat      (bus.bmem_rdata),
        .i_advance   (w_advance),
        .o_line      (w_line),
        .o_beat      (w_beat),
        .o_beat_cnt  (w_beat_cnt),
        .o_last      (w_last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= ARB_I;
            r_last_grant <= ARB_D;
            r_op_write   <= 1'b0;
            r_addr       <= '0;
            r_cool_i     <= 1'b0;
            r_cool_d     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cool_i <= (r_state == ARB_RESP) && (r_owner == ARB_I);
            r_cool_d <= (r_state == ARB_RESP) && (r_owner == ARB_D);
            if (r_state == ARB_RESP) r_last_grant <= r_owner;
            if (w_load) begin
                r_owner    <= w_grant;
                r_addr     <= line_align(w_grant_addr);
                r_op_write <= w_grant_write;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_shift_in   = 1'b0;
        w_advance    = 1'b0;
        w_bmem_read  = 1'b0;
        w_bmem_write = 1'b0;
        w_resp_i     = 1'b0;
        w_resp_d     = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_grant_en) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_grant_write ? ARB_WR_BURST : ARB_RD_ISSUE;
                end
            end
            ARB_RD_ISSUE: begin
                w_bmem_read = 1'b1;
                if (bus.bmem_ready) w_state_nxt = ARB_RD_WAIT;
            end
            ARB_RD_WAIT: begin
                if (bus.bmem_rvalid) begin
                    w_shift_in = 1'b1;
                    if (w_last_beat) w_state_nxt = ARB_RESP;
                end
            end
            ARB_WR_BURST: begin
                w_bmem_write = 1'b1;
                if (bus.bmem_ready) begin
                    w_advance = 1'b1;
                    if (w_last_beat) w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_resp_i    = (r_owner == ARB_I);
                w_resp_d    = (r_owner == ARB_D);
                w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign bus.bmem_read   = w_bmem_read;
    assign bus.bmem_write  = w_bmem_write;
    assign bus.bmem_addr   = (w_bmem_read | w_bmem_write) ? r_addr : '0;
    assign bus.bmem_wdata  = w_bmem_write ? w_beat : '0;
    assign bus.i_dfp_resp  = w_resp_i;
    assign bus.d_dfp_resp  = w_resp_d;
    assign bus.i_dfp_rdata = (w_resp_i && !r_op_write) ? w_line : '0;
    assign bus.d_dfp_rdata = (w_resp_d && !r_op_write) ? w_line : '0;

    assign o_state    = r_state;
    assign o_beat_cnt = w_beat_cnt;

    a_i_rd_wr_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.i_dfp_read && bus.i_dfp_write));
    a_d_rd_wr_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.d_dfp_read && bus.d_dfp_write));
    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
        bus.bmem_rvalid |-> (r_state == ARB_RD_WAIT));
    a_raddr_match: assert property (@(posedge clk) disable iff (rst)
        (bus.bmem_rvalid && r_state == ARB_RD_WAIT) |-> (bus.bmem_raddr == r_addr));

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: directed scenarios plus a randomized mix.
// Driven against a beat-level memory model, with per-cache expected-line queues.
module tb_bmem_arbiter;
    import bmem_arbiter_pkg::*;

    logic                  clk;
    logic                  rst;
    arb_state_t            dut_state;
    logic [BEAT_CNT_W-1:0] dut_beat_cnt;

    bmem_arbiter_if bus();

    bmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_state    (dut_state),
        .o_beat_cnt (dut_beat_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    logic [LINE_WIDTH-1:0] exp_i_q[$];
    logic [LINE_WIDTH-1:0] exp_d_q[$];
    logic                  exp_i_wr_q[$];
    logic                  exp_d_wr_q[$];
    logic                  exp_owner_q[$];
    logic [LINE_WIDTH-1:0] exp_wline[logic [ADDR_WIDTH-1:0]];

    // memory model knobs and counters
    logic ready_q[$];
    bit   rand_ready = 0;
    int   gap_min    = 0;
    int   gap_max    = 2;
    int   rd_cmds    = 0;
    int   rd_hi_cyc  = 0;
    int   wr_beats   = 0;
    logic [ADDR_WIDTH-1:0] last_cmd_addr = '0;

    task automatic check(input string tag, input logic [LINE_WIDTH-1:0] got,
                         input logic [LINE_WIDTH-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BEAT_WIDTH-1:0] mem_beat(input logic [ADDR_WIDTH-1:0] a, input int k);
        return {a ^ 32'h5a5a_0000 ^ 32'(k), ~a + 32'(k * 7)};
    endfunction

    function automatic logic [LINE_WIDTH-1:0] mem_line(input logic [ADDR_WIDTH-1:0] a);
        logic [LINE_WIDTH-1:0] l;
        for (int k = 0; k < BMEM_BEATS; k++) l[BEAT_WIDTH*k +: BEAT_WIDTH] = mem_beat(a, k);
        return l;
    endfunction

    function automatic logic [LINE_WIDTH-1:0] rand_line();
        logic [LINE_WIDTH-1:0] l;
        for (int k = 0; k < LINE_WIDTH/32; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bmem_read"},  bus.bmem_read,   0);
        check({tag, "_bmem_write"}, bus.bmem_write,  0);
        check({tag, "_bmem_addr"},  bus.bmem_addr,   0);
        check({tag, "_bmem_wdata"}, bus.bmem_wdata,  0);
        check({tag, "_i_resp"},     bus.i_dfp_resp,  0);
        check({tag, "_d_resp"},     bus.d_dfp_resp,  0);
        check({tag, "_i_rdata"},    bus.i_dfp_rdata, 0);
        check({tag, "_d_rdata"},    bus.d_dfp_rdata, 0);
        check({tag, "_state"},      dut_state,       ARB_IDLE);
        check({tag, "_beat_cnt"},   dut_beat_cnt,    0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        rst = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Raises one cache request, holds it until resp (plus hold_extra cycles), then drops it.
    task automatic do_req(input bit which, input bit wr, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [LINE_WIDTH-1:0] wline, input int hold_extra);
        logic [ADDR_WIDTH-1:0] al;
        bit done;
        al   = addr & LINE_MASK;
        done = 0;
        if (wr) exp_wline[al] = wline;
        @(negedge clk);
        if (which == 0) begin
            exp_i_q.push_back(wr ? wline : mem_line(al));
            exp_i_wr_q.push_back(wr);
            bus.i_dfp_addr = addr; bus.i_dfp_wdata = wline;
            bus.i_dfp_read = !wr;  bus.i_dfp_write = wr;
        end else begin
            exp_d_q.push_back(wr ? wline : mem_line(al));
            exp_d_wr_q.push_back(wr);
            bus.d_dfp_addr = addr; bus.d_dfp_wdata = wline;
            bus.d_dfp_read = !wr;  bus.d_dfp_write = wr;
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ((which == 0 && bus.i_dfp_resp) || (which == 1 && bus.d_dfp_resp)) begin
                done = 1;
                break;
            end
        end
        check(which ? "d_req_done" : "i_req_done", done, 1);
        repeat (hold_extra) @(negedge clk);
        if (which == 0) begin
            bus.i_dfp_read = 1'b0; bus.i_dfp_write = 1'b0;
        end else begin
            bus.d_dfp_read = 1'b0; bus.d_dfp_write = 1'b0;
        end
    endtask

    // ---------------- memory model ----------------
    initial begin : mem_model
        bit   rd_pend, prev_read, wr_held, r;
        int   rd_idx, rd_wait, wr_idx;
        logic [ADDR_WIDTH-1:0] rd_addr, prev_addr;
        logic [BEAT_WIDTH-1:0] held_data;
        logic [LINE_WIDTH-1:0] wl;
        rd_pend = 0; prev_read = 0; wr_held = 0; rd_idx = 0; rd_wait = 0; wr_idx = 0;
        rd_addr = '0; prev_addr = '0; held_data = '0;
        bus.bmem_ready = 1'b1; bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata = '0;   bus.bmem_raddr  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_pend = 0; prev_read = 0; wr_held = 0; wr_idx = 0;
                bus.bmem_rvalid = 1'b0;
                bus.bmem_ready  = 1'b1;
                continue;
            end
            bus.bmem_rvalid = 1'b0;
            if (rd_pend) begin
                if (rd_wait > 0) rd_wait--;
                else begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_raddr  = rd_addr;
                    bus.bmem_rdata  = mem_beat(rd_addr, rd_idx);
                    rd_idx++;
                    rd_wait = $urandom_range(gap_max, gap_min);
                    if (rd_idx == BMEM_BEATS) rd_pend = 0;
                end
            end
            if ((bus.bmem_read || bus.bmem_write) && ready_q.size() > 0) r = ready_q.pop_front();
            else r = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            bus.bmem_ready = r;
            check("rd_wr_excl", bus.bmem_read & bus.bmem_write, 0);
            if (prev_read) begin
                check("rd_hold_valid", bus.bmem_read, 1);
                check("rd_addr_stable", bus.bmem_addr, prev_addr);
            end
            prev_read = 0;
            if (bus.bmem_read) begin
                rd_hi_cyc++;
                check("issue_beat_cnt", dut_beat_cnt, 0);
                if (r) begin
                    rd_cmds++;
                    last_cmd_addr = bus.bmem_addr;
                    rd_pend = 1; rd_addr = bus.bmem_addr; rd_idx = 0;
                    rd_wait = $urandom_range(gap_max, gap_min);
                end else begin
                    prev_read = 1; prev_addr = bus.bmem_addr;
                end
            end
            if (wr_held) begin
                check("wr_hold_valid", bus.bmem_write, 1);
                check("wr_hold_data", bus.bmem_wdata, held_data);
            end
            wr_held = 0;
            if (bus.bmem_write) begin
                if (r) begin
                    wr_beats++;
                    if (exp_wline.exists(bus.bmem_addr)) begin
                        wl = exp_wline[bus.bmem_addr];
                        check("wr_beat", bus.bmem_wdata, wl[BEAT_WIDTH*wr_idx +: BEAT_WIDTH]);
                    end else check("wr_addr_known", 0, 1);
                    wr_idx = (wr_idx + 1) % BMEM_BEATS;
                end else begin
                    wr_held = 1; held_data = bus.bmem_wdata;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : resp_mon
        bit prev_i, prev_d, w;
        logic [LINE_WIDTH-1:0] e;
        prev_i = 0; prev_d = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("resp_excl", bus.i_dfp_resp & bus.d_dfp_resp, 0);
                if (bus.i_dfp_resp) begin
                    check("i_resp_pulse", prev_i, 0);
                    if (exp_i_q.size() == 0) check("i_resp_unexpected", 1, 0);
                    else begin
                        e = exp_i_q.pop_front(); w = exp_i_wr_q.pop_front();
                        if (!w) check("i_rdata", bus.i_dfp_rdata, e);
                    end
                    if (exp_owner_q.size() > 0) check("grant_order", ARB_I, exp_owner_q.pop_front());
                end
                if (bus.d_dfp_resp) begin
                    check("d_resp_pulse", prev_d, 0);
                    if (exp_d_q.size() == 0) check("d_resp_unexpected", 1, 0);
                    else begin
                        e = exp_d_q.pop_front(); w = exp_d_wr_q.pop_front();
                        if (!w) check("d_rdata", bus.d_dfp_rdata, e);
                    end
                    if (exp_owner_q.size() > 0) check("grant_order", ARB_D, exp_owner_q.pop_front());
                end
            end
            prev_i = bus.i_dfp_resp;
            prev_d = bus.d_dfp_resp;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int c0, h0, w0;
        bit reached;
        rst = 1'b1;
        bus.i_dfp_addr = '0; bus.i_dfp_read = 1'b0; bus.i_dfp_write = 1'b0; bus.i_dfp_wdata = '0;
        bus.d_dfp_addr = '0; bus.d_dfp_read = 1'b0; bus.d_dfp_write = 1'b0; bus.d_dfp_wdata = '0;
        do_reset();

        // single icache read
        c0 = rd_cmds;
        do_req(0, 0, 32'h1eceb004, '0, 0);
        check("t1_rd_cmds", rd_cmds - c0, 1);
        check("t1_cmd_addr", last_cmd_addr, 32'h1eceb000);

        // simultaneous requests after reset, then back-to-back alternation
        do_reset();
        exp_owner_q = {ARB_I, ARB_D, ARB_I, ARB_D};
        fork
            begin do_req(0, 0, 32'h0000_4000, '0, 0); do_req(0, 0, 32'h0000_4100, '0, 0); end
            begin do_req(1, 0, 32'h0000_8000, '0, 0); do_req(1, 0, 32'h0000_8100, '0, 0); end
        join
        check("t2_order_drained", exp_owner_q.size(), 0);

        // dcache write with a stalling ready pattern
        ready_q = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        w0 = wr_beats;
        do_req(1, 1, 32'h0000_1020, rand_line(), 0);
        check("t3_wr_beats", wr_beats - w0, 4);
        check("t3_ready_used", ready_q.size(), 0);

        // read command stalled for 5 cycles
        ready_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        h0 = rd_hi_cyc; c0 = rd_cmds;
        do_req(0, 0, 32'h0000_2468, '0, 0);
        check("t4_read_cycles", rd_hi_cyc - h0, 6);
        check("t4_rd_cmds", rd_cmds - c0, 1);

        // request held one cycle past resp is not served again
        c0 = rd_cmds;
        do_req(0, 0, 32'h0000_5000, '0, 1);
        repeat (3) @(negedge clk);
        check("t5_rd_cmds", rd_cmds - c0, 1);
        check("t5_idle", dut_state, ARB_IDLE);
        exp_owner_q = {ARB_I, ARB_D};
        fork
            do_req(0, 0, 32'h0000_5100, '0, 1);
            begin @(negedge clk); do_req(1, 0, 32'h0000_9100, '0, 0); end
        join
        check("t5_order_drained", exp_owner_q.size(), 0);

        // reset in the middle of a read
        gap_min = 3; gap_max = 3;
        @(negedge clk);
        bus.i_dfp_addr = 32'h0000_3300; bus.i_dfp_write = 1'b0; bus.i_dfp_read = 1'b1;
        reached = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (dut_beat_cnt == 2) begin reached = 1; break; end
        end
        check("t6_two_beats", reached, 1);
        rst = 1'b1; bus.i_dfp_read = 1'b0;
        @(negedge clk);
        check_outputs_zero("t6");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        gap_min = 0; gap_max = 2;
        do_req(0, 0, 32'h0000_3340, '0, 0);

        // randomized mix of reads and writes from both caches
        rand_ready = 1;
        for (int it = 0; it < 6; it++) begin
            fork
                do_req(0, 1'($urandom_range(1, 0)),
                       32'h1000_0000 + 32'(it * 64) + 32'($urandom_range(31, 0)), rand_line(), 0);
                do_req(1, 1'($urandom_range(1, 0)),
                       32'h2000_0000 + 32'(it * 64) + 32'($urandom_range(31, 0)), rand_line(), 0);
            join
        end
        rand_ready = 0;
        repeat (4) @(negedge clk);
        check("end_i_q_empty", exp_i_q.size(), 0);
        check("end_d_q_empty", exp_d_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
